// File: rtl/antilog_unshifter32_pkg.sv
// antilog_unshifter32_pkg
// Shared widths and state encoding for the antilog unshifter.
//   NUM_LENGTH : width of the reconstructed integer
//   K_LENGTH   : width of the leading-one index (log2 of NUM_LENGTH)
//   M1_LENGTH  : mantissa width below the hidden leading one
//   STEP_W     : width of the shift-step counter (must hold K_LENGTH)
package antilog_unshifter32_pkg;

  localparam int NUM_LENGTH = 32;
  localparam int K_LENGTH   = 5;
  localparam int M1_LENGTH  = 16;
  localparam int STEP_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/antilog_unshifter32.sv
// antilog_unshifter32
// Rebuilds num = floor((1.m1) * 2^k) from an encoded {k, m1} pair.
// The hidden one and mantissa are placed at the top of an accumulator, which
// is then right-shifted by (NUM_LENGTH-1-k) = ~k, one binary-weighted barrel
// stage per clock (largest distance first). A final edge publishes the result.
//
// state  | meaning
// IDLE   | waiting for a pair, in_ready high
// SHIFT  | applying one barrel stage per edge, then publishing on the last edge
// DONE   | result held on out_num / out_valid until out_ready
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   input handshake for {in_k, in_m1, in_zero}
//   in_k                leading-one index
//   in_m1               MSB-aligned fractional mantissa
//   in_zero             forces a zero result
//   out_valid/out_ready output handshake for out_num
//   out_num             reconstructed integer
//   busy                high in SHIFT or DONE
module antilog_unshifter32
  import antilog_unshifter32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [K_LENGTH-1:0]   in_k,
  input  logic [M1_LENGTH-1:0]  in_m1,
  input  logic                  in_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_LENGTH-1:0] out_num,
  output logic                  busy
);

  state_t                state_q, state_d;
  logic [NUM_LENGTH-1:0] acc_q, acc_d;
  logic [NUM_LENGTH-1:0] out_num_q, out_num_d;
  logic [K_LENGTH-1:0]   sh_q, sh_d;
  logic [STEP_W-1:0]     step_q, step_d;

  logic                  accept;
  logic [STEP_W-1:0]     stage_idx;
  logic [K_LENGTH-1:0]   stage_dist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      out_num_q <= '0;
      sh_q      <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      out_num_q <= out_num_d;
      sh_q      <= sh_d;
      step_q    <= step_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    accept     = in_valid && in_ready;
    // Step s uses distance 2^(K_LENGTH-1-s); the matching shift-amount bit is
    // always sh_q's MSB because sh_q is shifted left as stages are consumed.
    stage_idx  = STEP_W'(K_LENGTH - 1) - step_q;
    stage_dist = K_LENGTH'(1) << stage_idx;

    state_d   = state_q;
    acc_d     = acc_q;
    out_num_d = out_num_q;
    sh_d      = sh_q;
    step_d    = step_q;

    case (state_q)
      ST_SHIFT: begin
        if (step_q == STEP_W'(K_LENGTH)) begin
          state_d   = ST_DONE;
          out_num_d = acc_q;
        end else begin
          if (sh_q[K_LENGTH-1]) acc_d = acc_q >> stage_dist;
          sh_d   = sh_q << 1;
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DONE: begin
        // out_num is deliberately kept after the handshake.
        if (out_ready && !in_valid) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Covers both the IDLE accept and the back-to-back accept from DONE.
    if (accept) begin
      acc_d   = in_zero ? '0
                        : {1'b1, in_m1, {(NUM_LENGTH - M1_LENGTH - 1){1'b0}}};
      sh_d    = ~in_k;
      step_d  = '0;
      state_d = ST_SHIFT;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_num   = out_num_q;

endmodule

// File: tb/tb_antilog_unshifter32.sv
// Directed bench for antilog_unshifter32 with hand-computed expected values.
module tb_antilog_unshifter32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_k;
  logic [15:0] in_m1;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_num;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n;

  antilog_unshifter32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_k      (in_k),
    .in_m1     (in_m1),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid, returning the number of edges taken.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_pair(input string tag, input logic [4:0] k, input logic [15:0] m1,
                          input logic z, input logic [31:0] exp);
    int e;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_k      = k;
    in_m1     = m1;
    in_zero   = z;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_k     = ~k;
    in_m1    = ~m1;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(e);
    chk({tag, "_latency"}, e, 32'd6);
    chk({tag, "_num"}, out_num, exp);
    tick();
    chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_num_kept"}, out_num, exp);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_k      = '0;
    in_m1     = '0;
    in_zero   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_num", out_num, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_pair("k31_m0",    5'd31, 16'h0000, 1'b0, 32'h8000_0000);
    run_pair("k16_abcd",  5'd16, 16'hABCD, 1'b0, 32'h0001_ABCD);
    run_pair("k4_8000",   5'd4,  16'h8000, 1'b0, 32'd24);
    run_pair("k0_ffff",   5'd0,  16'hFFFF, 1'b0, 32'd1);
    run_pair("k0_0",      5'd0,  16'h0000, 1'b0, 32'd1);
    run_pair("zero_k7",   5'd7,  16'h1234, 1'b1, 32'd0);

    // Backpressure in DONE, then same-edge accept.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_k      = 5'd31;
    in_m1     = 16'hFFFF;
    in_zero   = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_done(n);
    chk("bp_latency", n, 32'd6);
    chk("bp_num", out_num, 32'hFFFF_8000);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_k     = 5'(i);
      tick();
      chk("bp_hold_num", out_num, 32'hFFFF_8000);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_k      = 5'd20;
    in_m1     = 16'h4000;
    #1;
    chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_shift_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("b2b_latency", n, 32'd6);
    chk("b2b_num", out_num, 32'h0014_0000);
    tick();

    // Inputs toggling during SHIFT are ignored.
    in_valid = 1'b1;
    in_k     = 5'd16;
    in_m1    = 16'hABCD;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_k     = 5'($urandom_range(0, 31));
      in_m1    = 16'($urandom);
      in_zero  = 1'($urandom);
      #1;
      chk("ign_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_zero  = 1'b0;
    tick();
    chk("ign_valid", {31'd0, out_valid}, 32'd1);
    chk("ign_num", out_num, 32'h0001_ABCD);
    tick();

    // Asynchronous reset during SHIFT step 2.
    in_valid = 1'b1;
    in_k     = 5'd31;
    in_m1    = 16'h0000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_num", out_num, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) n++;
    end
    chk("mid_rst_no_emit", n, 32'd0);
    run_pair("post_rst", 5'd4, 16'h8000, 1'b0, 32'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
